// File: rtl/ls169_cascade_if.sv
// Bus bundle for the ls169_cascade counter: load/count controls in, count and
// terminal-count chain out. The master modport drives controls; slave is the counter.
interface ls169_cascade_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic [W-1:0]       p;
  logic               pe_b;
  logic               cep;
  logic               cet;
  logic               ud;
  logic               ar;
  logic [W-1:0]       q;
  logic               tc_b;
  logic [NIBBLES-1:0] stage_tc_b;
  logic               wrap;

  modport master (
    output p, pe_b, cep, cet, ud, ar,
    input  q, tc_b, stage_tc_b, wrap
  );

  modport slave (
    input  p, pe_b, cep, cet, ud, ar,
    output q, tc_b, stage_tc_b, wrap
  );
endinterface

// File: rtl/ls169_cascade.sv
// Presettable up/down counter of NIBBLES cascaded 74LS169-style stages with an
// optional auto-reload register and active-low ripple terminal-count chain.
module ls169_cascade #(
  parameter int NIBBLES = 4
) (
  input logic            cp,
  input logic            mr_b,
  ls169_cascade_if.slave bus
);
  localparam int W = 4 * NIBBLES;

  logic [W-1:0]       q_q;
  logic [W-1:0]       q_d;
  logic [W-1:0]       rld_q;
  logic [W-1:0]       rld_d;
  logic               wrap_q;
  logic               wrap_d;
  logic               ce_s;
  logic               at_tc_s;
  logic [NIBBLES-1:0] stage_term_s;
  logic [NIBBLES-1:0] stage_tc_b_s;
  logic               run_s;

  // Per-stage terminal detect and the cet-gated ripple chain
  always_comb begin
    stage_term_s = {NIBBLES{1'b0}};
    stage_tc_b_s = {NIBBLES{1'b1}};
    run_s        = bus.cet;
    for (int i = 0; i < NIBBLES; i++) begin
      if (bus.ud) begin
        stage_term_s[i] = (q_q[4*i +: 4] == 4'hF);
      end else begin
        stage_term_s[i] = (q_q[4*i +: 4] == 4'h0);
      end
      run_s           = run_s & stage_term_s[i];
      stage_tc_b_s[i] = ~run_s;
    end
  end

  assign at_tc_s = &stage_term_s;
  assign ce_s    = bus.pe_b & bus.cep & bus.cet;

  // Next-state: load beats count beats hold; wrap marks terminal transitions only
  always_comb begin
    q_d    = q_q;
    rld_d  = rld_q;
    wrap_d = 1'b0;
    if (!bus.pe_b) begin
      q_d   = bus.p;
      rld_d = bus.p;
    end else if (ce_s) begin
      if (at_tc_s) begin
        wrap_d = 1'b1;
        if (bus.ar) begin
          q_d = rld_q;
        end else if (bus.ud) begin
          q_d = {W{1'b0}};
        end else begin
          q_d = {W{1'b1}};
        end
      end else if (bus.ud) begin
        q_d = q_q + {{(W-1){1'b0}}, 1'b1};
      end else begin
        q_d = q_q - {{(W-1){1'b0}}, 1'b1};
      end
    end else begin
      q_d = q_q;
    end
  end

  // State registers with asynchronous master reset
  always_ff @(posedge cp or negedge mr_b) begin
    if (!mr_b) begin
      q_q    <= {W{1'b0}};
      rld_q  <= {W{1'b0}};
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rld_q  <= rld_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q          = q_q;
  assign bus.wrap       = wrap_q;
  assign bus.stage_tc_b = stage_tc_b_s;
  assign bus.tc_b       = stage_tc_b_s[NIBBLES-1];
endmodule

// File: tb/tb_ls169_cascade.sv
// Directed self-checking bench for ls169_cascade (NIBBLES = 4), sampling on the
// falling edge of cp with hand-computed expectations.
module tb_ls169_cascade;
  logic cp;
  logic mr_b;
  int   checks;
  int   errors;

  ls169_cascade_if #(.NIBBLES(4)) bus ();

  ls169_cascade #(.NIBBLES(4)) dut (
    .cp   (cp),
    .mr_b (mr_b),
    .bus  (bus.slave)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cp);
    @(negedge cp);
  endtask

  task automatic load(input logic [15:0] val);
    bus.pe_b = 1'b0;
    bus.p    = val;
    tick();
    bus.pe_b = 1'b1;
  endtask

  initial begin
    logic [15:0] dn_q [5];
    logic        dn_tc [5];
    logic        dn_wr [5];
    checks = 0;
    errors = 0;
    mr_b = 1'b0;
    bus.p = 16'h0000; bus.pe_b = 1'b1; bus.cep = 1'b0; bus.cet = 1'b0;
    bus.ud = 1'b1;    bus.ar = 1'b0;
    @(negedge cp);
    check("rst_q", {16'h0, bus.q}, 32'h0);
    check("rst_wrap", {31'h0, bus.wrap}, 32'h0);
    mr_b = 1'b1;

    // Asynchronous reset mid-cycle from 1234
    load(16'h1234);
    check("ld_1234", {16'h0, bus.q}, 32'h1234);
    #2 mr_b = 1'b0;
    bus.ud = 1'b0; bus.cet = 1'b1;
    #1;
    check("async_rst_q", {16'h0, bus.q}, 32'h0);
    check("async_rst_wrap", {31'h0, bus.wrap}, 32'h0);
    check("async_rst_tc", {31'h0, bus.tc_b}, 32'h0);
    @(negedge cp);
    mr_b = 1'b1;

    // Load wins over count, then count up across the nibble boundary
    bus.cep = 1'b1; bus.cet = 1'b1; bus.ud = 1'b1;
    load(16'h00FF);
    check("ld_00ff", {16'h0, bus.q}, 32'h00FF);
    check("stage_tc_00ff", {28'h0, bus.stage_tc_b}, 32'hC);
    check("tc_00ff", {31'h0, bus.tc_b}, 32'h1);
    tick();
    check("up_0100", {16'h0, bus.q}, 32'h0100);
    check("up_0100_wrap", {31'h0, bus.wrap}, 32'h0);

    // Down-count with auto-reload of 3
    load(16'h0003);
    bus.ud = 1'b0; bus.ar = 1'b1;
    check("ar_start_tc", {31'h0, bus.tc_b}, 32'h1);
    dn_q  = '{16'h0002, 16'h0001, 16'h0000, 16'h0003, 16'h0002};
    dn_tc = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    dn_wr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ar_q", {16'h0, bus.q}, {16'h0, dn_q[i]});
      check("ar_tc", {31'h0, bus.tc_b}, {31'h0, dn_tc[i]});
      check("ar_wrap", {31'h0, bus.wrap}, {31'h0, dn_wr[i]});
    end

    // Natural wrap up
    bus.ar = 1'b0; bus.ud = 1'b1;
    load(16'hFFFE);
    tick();
    check("up_ffff", {16'h0, bus.q}, 32'hFFFF);
    check("up_ffff_tc", {31'h0, bus.tc_b}, 32'h0);
    check("up_ffff_wrap", {31'h0, bus.wrap}, 32'h0);
    tick();
    check("up_wrap_q", {16'h0, bus.q}, 32'h0000);
    check("up_wrap_pulse", {31'h0, bus.wrap}, 32'h1);
    check("up_wrap_tc", {31'h0, bus.tc_b}, 32'h1);
    tick();
    check("up_0001", {16'h0, bus.q}, 32'h0001);
    check("up_0001_wrap", {31'h0, bus.wrap}, 32'h0);

    // Natural wrap down
    bus.ud = 1'b0;
    load(16'h0001);
    tick();
    check("dn_0000", {16'h0, bus.q}, 32'h0000);
    check("dn_0000_tc", {31'h0, bus.tc_b}, 32'h0);
    check("dn_0000_wrap", {31'h0, bus.wrap}, 32'h0);
    tick();
    check("dn_wrap_q", {16'h0, bus.q}, 32'hFFFF);
    check("dn_wrap_pulse", {31'h0, bus.wrap}, 32'h1);
    check("dn_wrap_tc", {31'h0, bus.tc_b}, 32'h1);

    // Enable gating at zero counting down
    load(16'h0000);
    bus.cet = 1'b0;
    #1;
    check("gate_cet_tc", {31'h0, bus.tc_b}, 32'h1);
    check("gate_cet_stage", {28'h0, bus.stage_tc_b}, 32'hF);
    tick();
    check("gate_cet_q", {16'h0, bus.q}, 32'h0);
    bus.cet = 1'b1; bus.cep = 1'b0;
    #1;
    check("gate_cep_tc", {31'h0, bus.tc_b}, 32'h0);
    tick();
    check("gate_cep_q", {16'h0, bus.q}, 32'h0);
    check("gate_cep_wrap", {31'h0, bus.wrap}, 32'h0);

    // Direction flip while sitting at all ones
    bus.cep = 1'b1; bus.ud = 1'b1;
    load(16'hFFFF);
    check("flip_tc_up", {31'h0, bus.tc_b}, 32'h0);
    bus.ud = 1'b0;
    #1;
    check("flip_tc_dn", {31'h0, bus.tc_b}, 32'h1);
    tick();
    check("flip_q", {16'h0, bus.q}, 32'hFFFE);
    check("flip_wrap", {31'h0, bus.wrap}, 32'h0);

    // Reset discards reload value; reload of 0 gives back-to-back wraps
    load(16'h0005);
    mr_b = 1'b0;
    #1;
    mr_b = 1'b1;
    bus.ar = 1'b1; bus.ud = 1'b0;
    tick();
    check("rld0_q1", {16'h0, bus.q}, 32'h0);
    check("rld0_wrap1", {31'h0, bus.wrap}, 32'h1);
    tick();
    check("rld0_q2", {16'h0, bus.q}, 32'h0);
    check("rld0_wrap2", {31'h0, bus.wrap}, 32'h1);
    bus.cep = 1'b0;
    tick();
    check("rld0_wrap_off", {31'h0, bus.wrap}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
